vend_dispense_ctrl: RTL and testbench

//  Inventory and dispense sequencer behind the vending FSM. Holds a per-slot stock count and derives the

---
 rtl/vend_pkg.sv | 25 ++
 rtl/vend_stock_bank.sv | 72 +++++++
 rtl/vend_dispense_ctrl.sv | 145 ++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared constants for the vending dispense slice: FSM state codes, slot indices, timing defaults.
package vend_pkg;

  localparam int unsigned IDX_W = 2;

  localparam int unsigned DEF_NUM_ITEMS    = 4;
  localparam int unsigned DEF_CNT_W        = 4;
  localparam int unsigned DEF_MAX_STOCK    = 15;
  localparam int unsigned DEF_MOTOR_CYCLES = 8;
  localparam int unsigned DEF_DROP_TIMEOUT = 32;

  // Plain constants rather than an enum so legacy tooling sees a fixed encoding.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CHECK     = 3'd1;
  localparam logic [2:0] ST_MOTOR     = 3'd2;
  localparam logic [2:0] ST_WAIT_DROP = 3'd3;
  localparam logic [2:0] ST_REPORT    = 3'd4;
  localparam logic [2:0] ST_COOLDOWN  = 3'd5;

  localparam logic [IDX_W-1:0] SLOT0 = 2'd0;
  localparam logic [IDX_W-1:0] SLOT1 = 2'd1;
  localparam logic [IDX_W-1:0] SLOT2 = 2'd2;
  localparam logic [IDX_W-1:0] SLOT3 = 2'd3;

endpackage

// File: rtl/vend_stock_bank.sv
// Per-slot stock counters with saturating restock, guarded decrement, sticky jam bits and
// registered availability/fault flags.
module vend_stock_bank
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = DEF_NUM_ITEMS,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned MAX_STOCK = DEF_MAX_STOCK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_en,
  input  logic [IDX_W-1:0]     inc_item,
  input  logic [CNT_W-1:0]     inc_qty,
  input  logic                 dec_en,
  input  logic [IDX_W-1:0]     dec_item,
  input  logic                 jam_set,
  input  logic [IDX_W-1:0]     jam_item,
  input  logic                 jam_clr,
  input  logic [IDX_W-1:0]     query_item,
  output logic                 query_ok,
  output logic [NUM_ITEMS-1:0] available,
  output logic                 fault
);

  logic [CNT_W-1:0]     stock_q [NUM_ITEMS];
  logic [CNT_W-1:0]     stock_d [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] jam_q, jam_d;
  logic [CNT_W:0]       sum;

  // Next stock/jam values; one extra sum bit keeps the restock add from wrapping.
  always_comb begin
    jam_d = jam_q;
    sum   = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      stock_d[i] = stock_q[i];
      if (inc_en && inc_item == IDX_W'(i)) begin
        sum = {1'b0, stock_q[i]} + {1'b0, inc_qty};
        stock_d[i] = (sum > (CNT_W+1)'(MAX_STOCK)) ? CNT_W'(MAX_STOCK) : sum[CNT_W-1:0];
      end
      if (dec_en && dec_item == IDX_W'(i) && stock_d[i] != '0) begin
        stock_d[i] = stock_d[i] - 1'b1;
      end
    end
    if (jam_clr) jam_d = '0;
    // A jam detected in the same cycle as a clear must survive.
    if (jam_set) jam_d[jam_item] = 1'b1;
  end

  // Selected-slot readiness for the controller's CHECK decision.
  always_comb begin
    query_ok = (stock_q[query_item] != '0) && !jam_q[query_item];
  end

  // State and registered flags; flags follow the stored counters one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_q[i] <= '0;
      jam_q     <= '0;
      available <= '0;
      fault     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i]   <= stock_d[i];
        available[i] <= (stock_q[i] != '0) && !jam_q[i];
      end
      jam_q <= jam_d;
      fault <= |jam_q;
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: accepts a vend request, checks the slot, runs the motor for a fixed time,
// waits for the drop sensor and reports done/fail. Also gates the service restock port.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS    = DEF_NUM_ITEMS,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned MAX_STOCK    = DEF_MAX_STOCK,
  parameter int unsigned MOTOR_CYCLES = DEF_MOTOR_CYCLES,
  parameter int unsigned DROP_TIMEOUT = DEF_DROP_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vend_req,
  input  logic [IDX_W-1:0]     vend_item,
  output logic                 vend_busy,
  output logic                 vend_done,
  output logic                 vend_fail,
  output logic [NUM_ITEMS-1:0] motor_en,
  input  logic                 drop_sense,
  output logic [NUM_ITEMS-1:0] item_available,
  input  logic                 restock_we,
  input  logic [IDX_W-1:0]     restock_item,
  input  logic [CNT_W-1:0]     restock_qty,
  output logic                 fault,
  input  logic                 fault_clr
);

  localparam int unsigned TMAX    = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
  localparam int unsigned TIMER_W = $clog2(TMAX + 1);

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               drop_q, drop_d;
  logic               inc_en, dec_en, jam_set, query_ok;
  logic               report_done, report_fail;

  vend_stock_bank #(
    .NUM_ITEMS (NUM_ITEMS),
    .CNT_W     (CNT_W),
    .MAX_STOCK (MAX_STOCK)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .inc_en     (inc_en),
    .inc_item   (restock_item),
    .inc_qty    (restock_qty),
    .dec_en     (dec_en),
    .dec_item   (sel_q),
    .jam_set    (jam_set),
    .jam_item   (sel_q),
    .jam_clr    (fault_clr),
    .query_item (sel_q),
    .query_ok   (query_ok),
    .available  (item_available),
    .fault      (fault)
  );

  // FSM next state, timer and stock-bank commands.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    timer_d     = timer_q;
    drop_d      = drop_q;
    inc_en      = 1'b0;
    dec_en      = 1'b0;
    jam_set     = 1'b0;
    report_done = 1'b0;
    report_fail = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vend_req) begin
          sel_d   = vend_item;
          state_d = ST_CHECK;
        end else if (restock_we) begin
          inc_en = 1'b1;
        end
      end
      ST_CHECK: begin
        if (!query_ok) begin
          report_fail = 1'b1;
          state_d     = ST_REPORT;
        end else begin
          timer_d = TIMER_W'(MOTOR_CYCLES);
          drop_d  = 1'b0;
          state_d = ST_MOTOR;
        end
      end
      ST_MOTOR: begin
        // An early drop while the motor still runs counts as confirmation.
        if (drop_sense) drop_d = 1'b1;
        if (timer_q == TIMER_W'(1)) begin
          timer_d = TIMER_W'(DROP_TIMEOUT);
          state_d = ST_WAIT_DROP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_WAIT_DROP: begin
        if (drop_q || drop_sense) begin
          dec_en      = 1'b1;
          report_done = 1'b1;
          state_d     = ST_REPORT;
        end else if (timer_q == TIMER_W'(1)) begin
          jam_set     = 1'b1;
          report_fail = 1'b1;
          state_d     = ST_REPORT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_REPORT: state_d = ST_COOLDOWN;
      ST_COOLDOWN: begin
        // Hold here until the request drops so a held level cannot vend twice.
        if (!vend_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      timer_q   <= '0;
      drop_q    <= 1'b0;
      vend_busy <= 1'b0;
      vend_done <= 1'b0;
      vend_fail <= 1'b0;
      motor_en  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      timer_q   <= timer_d;
      drop_q    <= drop_d;
      vend_busy <= (state_d != ST_IDLE);
      vend_done <= report_done;
      vend_fail <= report_fail;
      motor_en  <= (state_d == ST_MOTOR) ? (NUM_ITEMS'(1) << sel_d) : '0;
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Randomized self-checking bench for vend_dispense_ctrl against a slot-level inventory model.
module tb_vend_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vend_req = 1'b0;
  logic [1:0] vend_item = '0;
  logic       vend_busy, vend_done, vend_fail;
  logic [3:0] motor_en;
  logic       drop_sense = 1'b0;
  logic [3:0] item_available;
  logic       restock_we = 1'b0;
  logic [1:0] restock_item = '0;
  logic [3:0] restock_qty = '0;
  logic       fault;
  logic       fault_clr = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference inventory: plain counts and jam flags per slot.
  int model_stock [4];
  bit model_jam   [4];

  always #5 clk = ~clk;

  vend_dispense_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .vend_req       (vend_req),
    .vend_item      (vend_item),
    .vend_busy      (vend_busy),
    .vend_done      (vend_done),
    .vend_fail      (vend_fail),
    .motor_en       (motor_en),
    .drop_sense     (drop_sense),
    .item_available (item_available),
    .restock_we     (restock_we),
    .restock_item   (restock_item),
    .restock_qty    (restock_qty),
    .fault          (fault),
    .fault_clr      (fault_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      model_stock[i] = 0;
      model_jam[i]   = 1'b0;
    end
  endtask

  task automatic do_restock(input int item, input int qty);
    restock_we   = 1'b1;
    restock_item = 2'(item);
    restock_qty  = 4'(qty);
    tick();
    restock_we = 1'b0;
    model_stock[item] = (model_stock[item] + qty > 15) ? 15 : model_stock[item] + qty;
  endtask

  // Let flags settle in IDLE and compare them with the model.
  task automatic settle_flags(input string tag);
    logic [3:0] exp_av;
    logic       exp_fault;
    repeat (3) tick();
    exp_fault = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_av[i] = (model_stock[i] != 0) && !model_jam[i];
      exp_fault = exp_fault | model_jam[i];
    end
    n_checks++;
    if (item_available !== exp_av) begin
      n_fails++;
      $display("FAIL %s avail: got %b want %b", tag, item_available, exp_av);
    end
    n_checks++;
    if (fault !== exp_fault) begin
      n_fails++;
      $display("FAIL %s fault: got %b want %b", tag, fault, exp_fault);
    end
  endtask

  // One vend transaction; drop_cyc = sample cycle with drop_sense high, -1 for none.
  task automatic do_vend(input int item, input int drop_cyc, input bit hold, input string tag);
    bit exp_done;
    int exp_cyc, exp_motor, cyc, motor_cnt, got_cyc;
    bit got, got_done, bad_motor, both;
    logic [3:0] want_motor;
    want_motor = 4'(1 << item);
    if (model_stock[item] == 0 || model_jam[item]) begin
      exp_done = 1'b0; exp_cyc = 2; exp_motor = 0;
    end else if (drop_cyc < 0) begin
      exp_done = 1'b0; exp_cyc = 42; exp_motor = 8;
      model_jam[item] = 1'b1;
    end else begin
      exp_done = 1'b1; exp_cyc = ((drop_cyc > 10) ? drop_cyc : 10) + 1; exp_motor = 8;
      model_stock[item]--;
    end
    vend_req  = 1'b1;
    vend_item = 2'(item);
    cyc = 0; motor_cnt = 0; got = 1'b0; got_done = 1'b0; got_cyc = -1;
    bad_motor = 1'b0; both = 1'b0;
    while (!got && cyc < 80) begin
      tick();
      cyc++;
      restock_we = 1'b0;
      vend_item  = 2'($urandom_range(0, 3));
      if (motor_en !== 4'b0) begin
        motor_cnt++;
        if (motor_en !== want_motor) bad_motor = 1'b1;
      end
      if (vend_done === 1'b1 || vend_fail === 1'b1) begin
        got = 1'b1; got_cyc = cyc; got_done = vend_done;
        both = vend_done & vend_fail;
      end
      drop_sense = (cyc == drop_cyc);
    end
    drop_sense = 1'b0;
    n_checks++;
    if (!got || got_done !== exp_done || got_cyc != exp_cyc || both) begin
      n_fails++;
      $display("FAIL %s result: got done=%0b at %0d want done=%0b at %0d", tag, got_done, got_cyc,
               exp_done, exp_cyc);
    end
    n_checks++;
    if (motor_cnt != exp_motor || bad_motor) begin
      n_fails++;
      $display("FAIL %s motor: got %0d cycles (bad=%0b) want %0d on %b", tag, motor_cnt, bad_motor,
               exp_motor, want_motor);
    end
    if (!hold) begin
      vend_req = 1'b0;
      cyc = 0;
      while (vend_busy === 1'b1 && cyc < 6) begin
        tick();
        cyc++;
      end
      n_checks++;
      if (vend_busy !== 1'b0) begin
        n_fails++;
        $display("FAIL %s busy: got %b want 0 after cooldown", tag, vend_busy);
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({vend_busy, vend_done, vend_fail, motor_en, item_available, fault} !== 12'b0) begin
      n_fails++;
      $display("FAIL reset_outputs: got %b want 0",
               {vend_busy, vend_done, vend_fail, motor_en, item_available, fault});
    end
    rst = 1'b1;
    tick();
    settle_flags("reset_flags");
  endtask

  task automatic test_basic_vend();
    do_restock(0, 3);
    settle_flags("basic_restock");
    do_vend(0, 11, 1'b0, "basic_vend");
    settle_flags("basic_after");
  endtask

  task automatic test_empty_slot();
    do_vend(2, 5, 1'b0, "empty_slot");
    settle_flags("empty_after");
  endtask

  task automatic test_jam();
    do_restock(1, 1);
    settle_flags("jam_restock");
    do_vend(1, -1, 1'b0, "jam_vend");
    settle_flags("jam_fault");
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    for (int i = 0; i < 4; i++) model_jam[i] = 1'b0;
    settle_flags("jam_cleared");
    do_vend(1, 14, 1'b0, "jam_stock_kept");
    settle_flags("jam_final");
  endtask

  task automatic test_saturation();
    do_restock(3, 14);
    do_restock(3, 5);
    settle_flags("sat_restock");
    // Restock and request in the same cycle: request wins, restock is dropped.
    restock_we   = 1'b1;
    restock_item = 2'd2;
    restock_qty  = 4'd5;
    do_vend(2, 6, 1'b0, "sat_priority");
    settle_flags("sat_priority_flags");
    for (int n = 0; n < 16; n++) do_vend(3, $urandom_range(2, 20), 1'b0, "sat_drain");
    settle_flags("sat_drained");
  endtask

  task automatic test_back_to_back();
    bit extra;
    do_restock(0, 2);
    do_vend(0, 12, 1'b1, "held_first");
    extra = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (motor_en !== 4'b0 || vend_done !== 1'b0 || vend_fail !== 1'b0 || vend_busy !== 1'b1)
        extra = 1'b1;
    end
    n_checks++;
    if (extra) begin
      n_fails++;
      $display("FAIL held_request: got activity while held want none (motor=%b busy=%b)",
               motor_en, vend_busy);
    end
    vend_req = 1'b0;
    repeat (3) tick();
    do_vend(0, 3, 1'b0, "held_second");
    settle_flags("held_flags");
  endtask

  task automatic test_reset_mid_motor();
    do_restock(0, 1);
    vend_req  = 1'b1;
    vend_item = 2'd0;
    repeat (4) tick();
    n_checks++;
    if (motor_en !== 4'b0001) begin
      n_fails++;
      $display("FAIL midrst_motor_on: got %b want 0001", motor_en);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({vend_busy, vend_done, vend_fail, motor_en, item_available, fault} !== 12'b0) begin
      n_fails++;
      $display("FAIL midrst_async: got %b want 0",
               {vend_busy, vend_done, vend_fail, motor_en, item_available, fault});
    end
    model_reset();
    vend_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    settle_flags("midrst_flags");
  endtask

  task automatic test_random();
    int item;
    for (int n = 0; n < 40; n++) begin
      item = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: do_restock(item, $urandom_range(0, 15));
        1: begin
          fault_clr = 1'b1;
          tick();
          fault_clr = 1'b0;
          for (int i = 0; i < 4; i++) model_jam[i] = 1'b0;
        end
        default: do_vend(item, ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(2, 41), 1'b0,
                         "rand_vend");
      endcase
      if (n % 8 == 7) settle_flags("rand_flags");
    end
    settle_flags("rand_final");
  endtask

  initial begin
    test_reset();
    test_basic_vend();
    test_empty_slot();
    test_jam();
    test_saturation();
    test_back_to_back();
    test_reset_mid_motor();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
